dcache_data_arb: RTL and testbench

- Sequencer and arbiter in front of the single-port D-cache data LUTRAM (128-bit line, 16 byte strobes, zero read latency, read-first).
- Shares the one RAM port between three requesters: the CPU load/store path, the eviction/writeback reader, and the AXI refill path.
- Assembles 32-bit refill beats into a full line and writes it with one RAM access.
- Sits between the D-cache controller and the data RAM instance.

---
 rtl/dcache_data_arb.sv | 203 ++++++++++++++++++++
 tb/tb_dcache_data_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_data_arb.sv
// dcache_data_arb: sequencer/arbiter in front of the single-port D-cache data
// LUTRAM (128-bit line, 16 byte strobes, combinational read, read-first).
// Shares the RAM port between the refill line write, the writeback reader and
// the CPU load/store path (fixed priority in that order). Refill beats of
// 32 bits are assembled into a line buffer and written with one RAM access.
// Optional feature: define DCACHE_ARB_STARVE_GUARD_EN to let a CPU that has
// lost STARVE_LIMIT consecutive cycles beat the writeback reader.
// STARVE_LIMIT must be at least 1 when the guard is enabled.

module dcache_data_arb #(
  parameter int INDEX_BITS   = 6,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [INDEX_BITS-1:0] cpu_req_index,
  input  logic [15:0]           cpu_req_strobe,
  input  logic [127:0]          cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [127:0]          cpu_resp_rdata,
  input  logic                  wb_req_valid,
  output logic                  wb_req_ready,
  input  logic [INDEX_BITS-1:0] wb_req_index,
  output logic                  wb_resp_valid,
  output logic [127:0]          wb_resp_rdata,
  input  logic                  refill_valid,
  output logic                  refill_ready,
  input  logic [INDEX_BITS-1:0] refill_index,
  input  logic [31:0]           refill_word,
  input  logic                  refill_last,
  output logic                  refill_err,
  output logic [INDEX_BITS-1:0] ram_addr,
  output logic [15:0]           ram_strobe,
  output logic [127:0]          ram_wdata,
  input  logic [127:0]          ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_COLLECT = 2'd1,
    R_WRITE   = 2'd2
  } refill_state_e;

  refill_state_e         state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [127:0]          line_q, line_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic                  err_q, err_d;

  logic                  cpu_resp_valid_q, cpu_resp_valid_d;
  logic [127:0]          cpu_resp_rdata_q, cpu_resp_rdata_d;
  logic                  wb_resp_valid_q, wb_resp_valid_d;
  logic [127:0]          wb_resp_rdata_q, wb_resp_rdata_d;

  logic                  refill_accept;
  logic                  line_done;
  logic                  cpu_grant;
  logic                  wb_grant;
  logic                  cpu_force;

  // Beats can be taken whenever the line buffer is not being written out.
  assign refill_ready  = (state_q != R_WRITE);
  assign refill_accept = refill_valid & refill_ready;
  assign busy          = (state_q != R_IDLE);
  assign refill_err    = err_q;

  // Refill sequencing: collect beats into the line buffer, then one write cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    index_d   = index_q;
    err_d     = 1'b0;
    line_done = 1'b0;
    case (state_q)
      R_IDLE, R_COLLECT: begin
        if (refill_accept) begin
          if (state_q == R_IDLE) begin
            index_d = refill_index;
            line_d  = '0;
          end
          line_d[{cnt_q, 5'd0} +: 32] = refill_word;
          cnt_d     = cnt_q + 2'd1;
          line_done = (cnt_q == 2'd3) | refill_last;
          if (line_done) begin
            state_d = R_WRITE;
            err_d   = refill_last ^ (cnt_q == 2'd3);
          end else begin
            state_d = R_COLLECT;
          end
        end
      end
      R_WRITE: begin
        state_d = R_IDLE;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = R_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign cpu_force = cpu_req_valid & (starve_q >= STARVE_W'(STARVE_LIMIT));

  // Count consecutive losing CPU cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req_valid || cpu_grant) begin
      starve_d = '0;
    end else if (starve_q < STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Guard compiled out: the CPU is never promoted above writeback.
  assign cpu_force = (STARVE_LIMIT < 0);
`endif

  // One grant per cycle; requesters are held off while reset is asserted so
  // the RAM never sees a write during reset.
  always_comb begin
    cpu_grant  = 1'b0;
    wb_grant   = 1'b0;
    ram_addr   = cpu_req_index;
    ram_strobe = 16'h0000;
    ram_wdata  = '0;
    if (state_q == R_WRITE) begin
      ram_addr   = index_q;
      ram_strobe = 16'hFFFF;
      ram_wdata  = line_q;
    end else if (resetn) begin
      if (wb_req_valid && !cpu_force) begin
        wb_grant = 1'b1;
        ram_addr = wb_req_index;
      end else if (cpu_req_valid) begin
        cpu_grant  = 1'b1;
        ram_addr   = cpu_req_index;
        ram_strobe = cpu_req_strobe;
        ram_wdata  = cpu_req_wdata;
      end
    end
  end

  assign cpu_req_ready = cpu_grant;
  assign wb_req_ready  = wb_grant;

  // Capture the pre-access line for whichever requester was granted.
  always_comb begin
    cpu_resp_valid_d = cpu_grant;
    cpu_resp_rdata_d = cpu_grant ? ram_rdata : cpu_resp_rdata_q;
    wb_resp_valid_d  = wb_grant;
    wb_resp_rdata_d  = wb_grant ? ram_rdata : wb_resp_rdata_q;
  end

  assign cpu_resp_valid = cpu_resp_valid_q;
  assign cpu_resp_rdata = cpu_resp_rdata_q;
  assign wb_resp_valid  = wb_resp_valid_q;
  assign wb_resp_rdata  = wb_resp_rdata_q;

  // State, line buffer and response registers; reset discards any partial line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= R_IDLE;
      cnt_q            <= 2'd0;
      line_q           <= '0;
      index_q          <= '0;
      err_q            <= 1'b0;
      cpu_resp_valid_q <= 1'b0;
      cpu_resp_rdata_q <= '0;
      wb_resp_valid_q  <= 1'b0;
      wb_resp_rdata_q  <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      line_q           <= line_d;
      index_q          <= index_d;
      err_q            <= err_d;
      cpu_resp_valid_q <= cpu_resp_valid_d;
      cpu_resp_rdata_q <= cpu_resp_rdata_d;
      wb_resp_valid_q  <= wb_resp_valid_d;
      wb_resp_rdata_q  <= wb_resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dcache_data_arb.sv
// tb_dcache_data_arb: bench for dcache_data_arb with an attached read-first
// RAM, a behavioural reference model checked every cycle, directed scenarios
// with literal expectations, and a randomized phase.

module tb_dcache_data_arb;

  localparam int IB     = 6;
  localparam int NLINES = 64;
  localparam int LIMIT  = 3;

  logic          clk;
  logic          resetn;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [IB-1:0] cpu_req_index;
  logic [15:0]   cpu_req_strobe;
  logic [127:0]  cpu_req_wdata;
  logic          cpu_resp_valid;
  logic [127:0]  cpu_resp_rdata;
  logic          wb_req_valid;
  logic          wb_req_ready;
  logic [IB-1:0] wb_req_index;
  logic          wb_resp_valid;
  logic [127:0]  wb_resp_rdata;
  logic          refill_valid;
  logic          refill_ready;
  logic [IB-1:0] refill_index;
  logic [31:0]   refill_word;
  logic          refill_last;
  logic          refill_err;
  logic [IB-1:0] ram_addr;
  logic [15:0]   ram_strobe;
  logic [127:0]  ram_wdata;
  logic [127:0]  ram_rdata;
  logic          busy;

  int nChecks = 0;
  int nPass   = 0;

  dcache_data_arb #(.INDEX_BITS(IB), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_index(cpu_req_index), .cpu_req_strobe(cpu_req_strobe),
    .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_index(wb_req_index), .wb_resp_valid(wb_resp_valid),
    .wb_resp_rdata(wb_resp_rdata),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_index(refill_index), .refill_word(refill_word),
    .refill_last(refill_last), .refill_err(refill_err),
    .ram_addr(ram_addr), .ram_strobe(ram_strobe), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM: combinational read, byte-strobed write at the clock edge.
  logic [127:0] mem [NLINES];
  assign ram_rdata = mem[ram_addr];

  initial begin
    for (int i = 0; i < NLINES; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      for (int b = 0; b < 16; b++)
        if (ram_strobe[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else nPass++;
  endtask

  // Reference model state: expected line contents, beats collected so far,
  // whether a completed line is waiting for its write cycle, and pending responses.
  logic [127:0]  gm [NLINES];
  logic [31:0]   words [$];
  logic [IB-1:0] lineIdx;
  logic          pendWrite;
  logic          expErr;
  logic          expCpuV, expWbV;
  logic [127:0]  expCpuD, expWbD;
  int            waitCnt;
  logic          gRef, gWb, gCpu, promote;
  logic [127:0]  lineVal;

  function automatic logic [127:0] assembledLine();
    logic [127:0] v = '0;
    for (int i = 0; i < words.size(); i++) v[32*i +: 32] = words[i];
    return v;
  endfunction

  task automatic modelReset();
    words.delete();
    pendWrite = 1'b0;
    expErr    = 1'b0;
    expCpuV   = 1'b0;
    expWbV    = 1'b0;
    expCpuD   = '0;
    expWbD    = '0;
    waitCnt   = 0;
  endtask

  // Every cycle: predict outputs at the falling edge, advance the model at the rising edge.
  initial begin
    for (int i = 0; i < NLINES; i++) gm[i] = '0;
    lineIdx = '0;
    modelReset();
    forever begin
      @(negedge clk);
      if (!resetn) begin
        modelReset();
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_refill_ready", 128'(refill_ready), 128'(1));
        checkOutput("rst_refill_err", 128'(refill_err), 128'(0));
        checkOutput("rst_cpu_ready", 128'(cpu_req_ready), 128'(0));
        checkOutput("rst_wb_ready", 128'(wb_req_ready), 128'(0));
        checkOutput("rst_cpu_resp_valid", 128'(cpu_resp_valid), 128'(0));
        checkOutput("rst_wb_resp_valid", 128'(wb_resp_valid), 128'(0));
        checkOutput("rst_cpu_rdata", cpu_resp_rdata, '0);
        checkOutput("rst_wb_rdata", wb_resp_rdata, '0);
        checkOutput("rst_ram_strobe", 128'(ram_strobe), 128'(0));
      end else begin
        lineVal = assembledLine();
        promote = 1'b0;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
        promote = cpu_req_valid && (waitCnt >= LIMIT);
`endif
        gRef = pendWrite;
        gWb  = !gRef && wb_req_valid && !promote;
        gCpu = !gRef && cpu_req_valid && (!wb_req_valid || promote);
        checkOutput("cpu_req_ready", 128'(cpu_req_ready), 128'(gCpu));
        checkOutput("wb_req_ready", 128'(wb_req_ready), 128'(gWb));
        checkOutput("refill_ready", 128'(refill_ready), 128'(!pendWrite));
        checkOutput("busy", 128'(busy), 128'(pendWrite || words.size() > 0));
        checkOutput("refill_err", 128'(refill_err), 128'(expErr));
        checkOutput("cpu_resp_valid", 128'(cpu_resp_valid), 128'(expCpuV));
        checkOutput("cpu_resp_rdata", cpu_resp_rdata, expCpuD);
        checkOutput("wb_resp_valid", 128'(wb_resp_valid), 128'(expWbV));
        checkOutput("wb_resp_rdata", wb_resp_rdata, expWbD);
        if (gRef) begin
          checkOutput("ram_addr_refill", 128'(ram_addr), 128'(lineIdx));
          checkOutput("ram_strobe_refill", 128'(ram_strobe), 128'(16'hFFFF));
          checkOutput("ram_wdata_refill", ram_wdata, lineVal);
        end else if (gWb) begin
          checkOutput("ram_addr_wb", 128'(ram_addr), 128'(wb_req_index));
          checkOutput("ram_strobe_wb", 128'(ram_strobe), 128'(0));
        end else if (gCpu) begin
          checkOutput("ram_addr_cpu", 128'(ram_addr), 128'(cpu_req_index));
          checkOutput("ram_strobe_cpu", 128'(ram_strobe), 128'(cpu_req_strobe));
          checkOutput("ram_wdata_cpu", ram_wdata, cpu_req_wdata);
        end else begin
          checkOutput("ram_addr_idle", 128'(ram_addr), 128'(cpu_req_index));
          checkOutput("ram_strobe_idle", 128'(ram_strobe), 128'(0));
          checkOutput("ram_wdata_idle", ram_wdata, '0);
        end
      end
      @(posedge clk);
      if (resetn) begin
        expCpuV = gCpu;
        expWbV  = gWb;
        if (gCpu) expCpuD = gm[cpu_req_index];
        if (gWb)  expWbD  = gm[wb_req_index];
        if (gRef) gm[lineIdx] = lineVal;
        if (gCpu)
          for (int b = 0; b < 16; b++)
            if (cpu_req_strobe[b]) gm[cpu_req_index][8*b +: 8] = cpu_req_wdata[8*b +: 8];
        expErr = 1'b0;
        if (pendWrite) begin
          pendWrite = 1'b0;
          words.delete();
        end else if (refill_valid) begin
          if (words.size() == 0) lineIdx = refill_index;
          words.push_back(refill_word);
          if (words.size() == 4 || refill_last) begin
            pendWrite = 1'b1;
            expErr    = (refill_last != (words.size() == 4));
          end
        end
        if (cpu_req_valid && !gCpu) waitCnt = (waitCnt < LIMIT) ? waitCnt + 1 : LIMIT;
        else waitCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input logic cv, input logic [IB-1:0] ci, input logic [15:0] cs,
                               input logic [127:0] cw, input logic wv, input logic [IB-1:0] wi,
                               input logic rv, input logic [IB-1:0] ri, input logic [31:0] rw,
                               input logic rl);
    @(posedge clk);
    #1;
    cpu_req_valid  = cv;
    cpu_req_index  = ci;
    cpu_req_strobe = cs;
    cpu_req_wdata  = cw;
    wb_req_valid   = wv;
    wb_req_index   = wi;
    refill_valid   = rv;
    refill_index   = ri;
    refill_word    = rw;
    refill_last    = rl;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input logic [IB-1:0] ri, input logic [31:0] rw, input logic rl);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, ri, rw, rl);
  endtask

  localparam logic [127:0] A5LINE  = {16{8'hA5}};
  localparam logic [127:0] LINE9   = 128'h44444444_33333333_22222222_11111111;

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    resetn = 1'b0;
    cpu_req_valid = 0; cpu_req_index = 0; cpu_req_strobe = 0; cpu_req_wdata = 0;
    wb_req_valid = 0; wb_req_index = 0;
    refill_valid = 0; refill_index = 0; refill_word = 0; refill_last = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    applyStimulus(1, 5, 16'hFFFF, A5LINE, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("lit_cpu_write_grant", 128'(cpu_req_ready), 128'(1));
    applyStimulus(1, 5, 16'h0000, '0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("lit_write_resp_valid", 128'(cpu_resp_valid), 128'(1));
    checkOutput("lit_write_resp_old", cpu_resp_rdata, '0);
    idle();
    #2 checkOutput("lit_read_back", cpu_resp_rdata, A5LINE);

    beat(9, 32'h11111111, 0);
    beat(9, 32'h22222222, 0);
    beat(9, 32'h33333333, 0);
    beat(9, 32'h44444444, 1);
    idle();
    #2 checkOutput("lit_refill_addr", 128'(ram_addr), 128'(9));
    checkOutput("lit_refill_wdata", ram_wdata, LINE9);
    checkOutput("lit_refill_err_0", 128'(refill_err), 128'(0));
    idle();
    #2 checkOutput("lit_busy_low", 128'(busy), 128'(0));

    beat(12, 32'hAAAA0001, 0);
    beat(12, 32'hBBBB0002, 1);
    idle();
    #2 checkOutput("lit_short_wdata", ram_wdata, 128'h00000000_00000000_BBBB0002_AAAA0001);
    checkOutput("lit_short_err", 128'(refill_err), 128'(1));
    idle();
    #2 checkOutput("lit_short_err_once", 128'(refill_err), 128'(0));

    beat(20, 32'h5, 0);
    beat(20, 32'h6, 0);
    beat(20, 32'h7, 0);
    beat(20, 32'h8, 1);
    applyStimulus(1, 5, 0, 0, 1, 9, 0, 0, 0, 0);
    #2 checkOutput("lit_cont_refill_addr", 128'(ram_addr), 128'(20));
    checkOutput("lit_cont_wb_wait", 128'(wb_req_ready), 128'(0));
    applyStimulus(1, 5, 0, 0, 1, 9, 0, 0, 0, 0);
    #2 checkOutput("lit_cont_wb_grant", 128'(wb_req_ready), 128'(1));
    checkOutput("lit_cont_cpu_wait", 128'(cpu_req_ready), 128'(0));
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("lit_cont_cpu_grant", 128'(cpu_req_ready), 128'(1));
    checkOutput("lit_cont_wb_data", wb_resp_rdata, LINE9);
    idle();
    #2 checkOutput("lit_cont_cpu_data", cpu_resp_rdata, A5LINE);

    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1, 5, 0, 0, 1, 9, 0, 0, 0, 0);
`ifdef DCACHE_ARB_STARVE_GUARD_EN
      #2 checkOutput($sformatf("lit_starve_%0d", k), 128'(cpu_req_ready), 128'(k == 4));
`else
      #2 checkOutput($sformatf("lit_starve_%0d", k), 128'(cpu_req_ready), 128'(0));
`endif
    end
    idle();

    beat(30, 32'hDEAD0001, 0);
    beat(30, 32'hDEAD0002, 0);
    idle();
    #1 resetn = 1'b0;
    #1 checkOutput("lit_midrst_busy", 128'(busy), 128'(0));
    checkOutput("lit_midrst_refill_ready", 128'(refill_ready), 128'(1));
    @(posedge clk);
    #1 resetn = 1'b1;
    beat(30, 32'hC0000001, 0);
    beat(30, 32'hC0000002, 0);
    beat(30, 32'hC0000003, 0);
    beat(30, 32'hC0000004, 1);
    idle();
    #2 checkOutput("lit_after_rst_wdata", ram_wdata, 128'hC0000004_C0000003_C0000002_C0000001);

    repeat (500) begin
      applyStimulus($urandom_range(0, 1) == 1, IB'($urandom_range(0, NLINES - 1)),
                    ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom),
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 2) == 0, IB'($urandom_range(0, NLINES - 1)),
                    $urandom_range(0, 1) == 1, IB'($urandom_range(0, NLINES - 1)),
                    $urandom, $urandom_range(0, 3) == 0);
    end
    repeat (3) idle();
    @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
